// File: rtl/ram_access_arbiter_pkg.sv
// Shared state encoding, port indices and default widths for the RAM access arbiter.
package ram_access_arbiter_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    localparam int PORT_C = 0;
    localparam int PORT_L = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

endpackage

// File: rtl/ram_access_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on contention the port not served last wins.
module rr_arb2
    import ram_access_arbiter_pkg::*;
(
    input  logic [1:0] elig,
    input  logic       last_l,
    output logic [1:0] pick
);

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        pick = elig;
        if (elig == 2'b11) begin
            pick = 2'b00;
            if (last_l) begin
                pick[PORT_C] = 1'b1;
            end else begin
                pick[PORT_L] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port synchronous RAM between the CPU (C) and the loader (L),
// sequencing each access through ACCESS, an optional read WAIT, and a one-cycle ACK.
module ram_access_arbiter
    import ram_access_arbiter_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(12)
) (
    input  logic              SysClock,
    input  logic              ResetN,
    input  logic              CReq,
    input  logic              CWe,
    input  logic [ADDR_W-1:0] CAddr,
    input  logic [DATA_W-1:0] CWdata,
    output logic              CAck,
    output logic [DATA_W-1:0] CRdata,
    output logic              CErr,
    input  logic              LReq,
    input  logic              LWe,
    input  logic [ADDR_W-1:0] LAddr,
    input  logic [DATA_W-1:0] LWdata,
    output logic              LAck,
    output logic [DATA_W-1:0] LRdata,
    input  logic              LoaderOnly,
    input  logic              WrProt,
    output logic [1:0]        Gnt,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [DATA_W-1:0] RamData,
    output logic              RamWren,
    input  logic [DATA_W-1:0] RamQ
);

    state_e              state_q, state_d;
    logic                owner_l_q, owner_l_d;
    logic                last_l_q, last_l_d;
    logic                we_q, we_d;
    logic                supp_q, supp_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0]   l_rdata_q, l_rdata_d;
    logic [1:0]          elig;
    logic [1:0]          pick;

    always_comb begin
        elig         = 2'b00;
        elig[PORT_C] = CReq & ~LoaderOnly;
        elig[PORT_L] = LReq;
    end

    rr_arb2 u_rr_arb2 (
        .elig   (elig),
        .last_l (last_l_q),
        .pick   (pick)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the read-data holding registers are plain flops and are reset; the RAM array lives outside and is not.
    always_ff @(posedge SysClock or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= ST_IDLE;
            owner_l_q  <= 1'b0;
            last_l_q   <= 1'b1;
            we_q       <= 1'b0;
            supp_q     <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_l_q  <= owner_l_d;
            last_l_q   <= last_l_d;
            we_q       <= we_d;
            supp_q     <= supp_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            c_rdata_q  <= c_rdata_d;
            l_rdata_q  <= l_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (pick != 2'b00) state_d = ST_ACCESS;
            ST_ACCESS: state_d = we_q ? ST_ACK : ST_WAIT;
            ST_WAIT:   state_d = ST_ACK;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Winner's request is latched at grant time, so later input changes cannot disturb the access.
    always_comb begin
        owner_l_d  = owner_l_q;
        last_l_d   = last_l_q;
        we_d       = we_q;
        supp_d     = supp_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        c_rdata_d  = c_rdata_q;
        l_rdata_d  = l_rdata_q;
        if (state_q == ST_IDLE && pick != 2'b00) begin
            owner_l_d  = pick[PORT_L];
            last_l_d   = pick[PORT_L];
            we_d       = pick[PORT_L] ? LWe : CWe;
            ram_addr_d = pick[PORT_L] ? LAddr : CAddr;
            ram_data_d = pick[PORT_L] ? LWdata : CWdata;
            supp_d     = pick[PORT_C] & CWe & WrProt & (CAddr >= PROT_BASE);
        end
        if (state_q == ST_WAIT) begin
            if (owner_l_q) begin
                l_rdata_d = RamQ;
            end else begin
                c_rdata_d = RamQ;
            end
        end
    end

    always_comb begin
        Gnt     = 2'b00;
        CAck    = 1'b0;
        LAck    = 1'b0;
        CErr    = 1'b0;
        RamWren = 1'b0;
        if (state_q != ST_IDLE) begin
            Gnt[PORT_L] = owner_l_q;
            Gnt[PORT_C] = ~owner_l_q;
        end
        if (state_q == ST_ACCESS) begin
            RamWren = we_q & ~supp_q;
        end
        if (state_q == ST_ACK) begin
            LAck = owner_l_q;
            CAck = ~owner_l_q;
            CErr = ~owner_l_q & supp_q;
        end
    end

    assign RamAddr = ram_addr_q;
    assign RamData = ram_data_q;
    assign CRdata  = c_rdata_q;
    assign LRdata  = l_rdata_q;

endmodule
